// File: rtl/carry_chain_sequencer.sv
// rtl/carry_chain_sequencer.sv - WIDTH-bit add/sub sequenced chunk-by-chunk through one external SLICE-bit carry slice
module carry_chain_sequencer #(
  parameter int WIDTH = 32,
  parameter int SLICE = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             co_o,
  output logic             ovf_o,
  output logic [SLICE-1:0] slice_s_o,
  output logic [SLICE-1:0] slice_di_o,
  output logic             slice_ci_o,
  output logic             slice_ci_init_o,
  input  logic [SLICE-1:0] slice_o_i,
  input  logic [SLICE-1:0] slice_co_i
);

  localparam int NCHUNK = WIDTH / SLICE;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  generate
    if ((WIDTH % SLICE) != 0) begin : g_bad_width
      $error("carry_chain_sequencer: WIDTH must be a multiple of SLICE");
    end
    if (SLICE < 2) begin : g_bad_slice
      $error("carry_chain_sequencer: SLICE must be at least 2");
    end
  endgenerate

  logic [1:0]       state_q, state_d;
  logic [IDXW-1:0]  idx_q, idx_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             sub_q, sub_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             co_q, co_d;
  logic             ovf_q, ovf_d;

  logic             run;
  logic             accept;
  logic [31:0]      chunk_base;
  logic [SLICE-1:0] a_chunk;
  logic [SLICE-1:0] b_chunk;

  assign run         = (state_q == ST_RUN);
  assign in_ready_o  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready_i);
  assign accept      = in_valid_i & in_ready_o;
  assign out_valid_o = (state_q == ST_DONE);
  assign sum_o       = sum_q;
  assign co_o        = co_q;
  assign ovf_o       = ovf_q;

  assign chunk_base = 32'(idx_q) * SLICE;
  assign a_chunk    = a_q[chunk_base +: SLICE];
  assign b_chunk    = b_q[chunk_base +: SLICE];

  // Chunk 0 takes its carry from CI_INIT (the subtract +1); later chunks chain the stored carry.
  assign slice_s_o       = run ? (a_chunk ^ b_chunk) : '0;
  assign slice_di_o      = run ? a_chunk : '0;
  assign slice_ci_o      = run & (idx_q != '0) & carry_q;
  assign slice_ci_init_o = run & (idx_q == '0) & sub_q;

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    carry_d = carry_q;
    a_d     = a_q;
    b_d     = b_q;
    sub_d   = sub_q;
    sum_d   = sum_q;
    co_d    = co_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (accept) begin
          a_d     = a_i;
          b_d     = sub_i ? ~b_i : b_i;
          sub_d   = sub_i;
          idx_d   = '0;
          carry_d = 1'b0;
          state_d = ST_RUN;
        end else if (state_q == ST_DONE && out_ready_i) begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sum_d[chunk_base +: SLICE] = slice_o_i;
        carry_d = slice_co_i[SLICE-1];
        if (idx_q == LAST_IDX) begin
          // Overflow is carry into the MSB differing from carry out of it.
          co_d    = slice_co_i[SLICE-1];
          ovf_d   = slice_co_i[SLICE-1] ^ slice_co_i[SLICE-2];
          idx_d   = '0;
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sub_q   <= 1'b0;
      sum_q   <= '0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      carry_q <= carry_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sub_q   <= sub_d;
      sum_q   <= sum_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
